// File: rtl/fp_dot_product_chunk_sequencer_if.sv
// Bundle between the dot-product chunk sequencer, its operand memories and the ALU.
// Latency: none, wires only.
// Backpressure: none; the ALU answers through alu_valid, memories answer one cycle after mem_rd_en.
interface fp_dot_product_chunk_sequencer_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 5,
    parameter int MAX_LEN    = 170,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1),
    parameter int ADDR_WIDTH = (((MAX_LEN + NUM_INPUTS - 1) / NUM_INPUTS) > 1) ?
                               $clog2((MAX_LEN + NUM_INPUTS - 1) / NUM_INPUTS) : 1
);
    logic                          start;
    logic [LEN_WIDTH-1:0]          len;
    logic                          busy;
    logic                          done;
    logic [WIDTH-1:0]              result;
    logic                          mem_rd_en;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [WIDTH*NUM_INPUTS-1:0]   mem_a_data;
    logic [WIDTH*NUM_INPUTS-1:0]   mem_b_data;
    logic [WIDTH*NUM_INPUTS-1:0]   alu_a;
    logic [WIDTH*NUM_INPUTS-1:0]   alu_b;
    logic [WIDTH-1:0]              alu_c;
    logic [NUM_INPUTS-1:0]         alu_enable;
    logic                          alu_ready;
    logic                          alu_mode;
    logic [WIDTH-1:0]              alu_out;
    logic                          alu_valid;

    // Environment side: requester, operand memories and the ALU.
    modport master (
        output start, len, mem_a_data, mem_b_data, alu_out, alu_valid,
        input  busy, done, result, mem_rd_en, mem_addr,
               alu_a, alu_b, alu_c, alu_enable, alu_ready, alu_mode
    );

    // Sequencer side.
    modport slave (
        input  start, len, mem_a_data, mem_b_data, alu_out, alu_valid,
        output busy, done, result, mem_rd_en, mem_addr,
               alu_a, alu_b, alu_c, alu_enable, alu_ready, alu_mode
    );
endinterface

// File: rtl/fp_dot_product_chunk_sequencer.sv
// Splits a len-element FP dot product into NUM_INPUTS-wide chunks, feeding the partial sum back via alu_c.
// Latency: nchunks*(L+3)+1 cycles from accepted start to done (L = ALU latency); len=0 finishes in 1 cycle.
// Backpressure: one chunk in flight; start is ignored while busy, alu_valid is only honoured in WAIT.
// Option FP_CHUNK_SEQ_ZERO_MASKED_LANES_EN: force disabled alu_a/alu_b lanes to zero.
module fp_dot_product_chunk_sequencer #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 5,
    parameter int MAX_LEN    = 170,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1),
    parameter int ADDR_WIDTH = (((MAX_LEN + NUM_INPUTS - 1) / NUM_INPUTS) > 1) ?
                               $clog2((MAX_LEN + NUM_INPUTS - 1) / NUM_INPUTS) : 1
) (
    input logic clk,
    input logic rst,
    fp_dot_product_chunk_sequencer_if.slave bus
);
    // k runs up to nchunks, one past the last chunk address.
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam int SUM_WIDTH = $clog2(MAX_LEN + NUM_INPUTS);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

    state_t                      state;
    state_t                      state_nx;
    logic [CNT_WIDTH-1:0]        nchunks;
    logic [CNT_WIDTH-1:0]        k;
    logic [CNT_WIDTH-1:0]        k_inc;
    logic [CNT_WIDTH-1:0]        nchunks_calc;
    logic [SUM_WIDTH-1:0]        len_sum;
    logic [LEN_WIDTH-1:0]        last_lane;
    logic [NUM_INPUTS-1:0]       mask_calc;
    logic [NUM_INPUTS-1:0]       last_mask;
    logic [NUM_INPUTS-1:0]       enable;
    logic [WIDTH-1:0]            acc;
    logic [WIDTH-1:0]            result_q;
    logic [WIDTH*NUM_INPUTS-1:0] alu_a_w;
    logic [WIDTH*NUM_INPUTS-1:0] alu_b_w;
    logic [ADDR_WIDTH-1:0]       addr;
    logic                        more;
    logic                        busy;
    logic                        done;
    logic                        rd_en;
    logic                        ready;

    // Decode len at start: chunk count and the lane mask of the final, possibly partial, chunk.
    always_comb begin
        len_sum      = SUM_WIDTH'(bus.len) + SUM_WIDTH'(NUM_INPUTS - 1);
        nchunks_calc = CNT_WIDTH'(len_sum / SUM_WIDTH'(NUM_INPUTS));
        // Highest live lane of the last chunk; meaningless for len=0, which never issues.
        last_lane    = (bus.len - LEN_WIDTH'(1)) % LEN_WIDTH'(NUM_INPUTS);
        mask_calc    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            mask_calc[i] = (LEN_WIDTH'(i) <= last_lane);
        end
    end

    assign k_inc = k + CNT_WIDTH'(1);
    assign more  = (k_inc < nchunks);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-state strobes.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        rd_en    = 1'b0;
        addr     = '0;
        ready    = 1'b0;
        enable   = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_nx = (bus.len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rd_en    = 1'b1;
                addr     = k[ADDR_WIDTH-1:0];
                state_nx = ISSUE;
            end
            ISSUE: begin
                ready    = 1'b1;
                enable   = more ? '1 : last_mask;
                state_nx = WAIT;
            end
            WAIT: begin
                if (bus.alu_valid) begin
                    state_nx = more ? FETCH : DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Chunk counter, running sum and result register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            nchunks   <= '0;
            k         <= '0;
            last_mask <= '0;
            acc       <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        nchunks   <= nchunks_calc;
                        last_mask <= mask_calc;
                        k         <= '0;
                        acc       <= '0;
                        if (bus.len == '0) begin
                            result_q <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (bus.alu_valid) begin
                        acc <= bus.alu_out;
                        k   <= k_inc;
                        // Capture on the way into DONE so result is valid alongside done.
                        if (!more) begin
                            result_q <= bus.alu_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FP_CHUNK_SEQ_ZERO_MASKED_LANES_EN
    // Zero disabled lanes so NaN/Inf memory contents never reach the multipliers.
    always_comb begin
        alu_a_w = bus.mem_a_data;
        alu_b_w = bus.mem_b_data;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!enable[i]) begin
                alu_a_w[WIDTH*i +: WIDTH] = '0;
                alu_b_w[WIDTH*i +: WIDTH] = '0;
            end
        end
    end
`else
    // Memory data goes straight through; alu_enable alone masks lanes.
    always_comb begin
        alu_a_w = bus.mem_a_data;
        alu_b_w = bus.mem_b_data;
    end
`endif

    assign bus.busy       = busy;
    assign bus.alu_mode   = busy;
    assign bus.done       = done;
    assign bus.result     = result_q;
    assign bus.mem_rd_en  = rd_en;
    assign bus.mem_addr   = addr;
    assign bus.alu_ready  = ready;
    assign bus.alu_enable = enable;
    assign bus.alu_c      = acc;
    assign bus.alu_a      = alu_a_w;
    assign bus.alu_b      = alu_b_w;
endmodule

// File: tb/tb_fp_dot_product_chunk_sequencer.sv
// Scoreboard bench for fp_dot_product_chunk_sequencer with behavioural operand memories and ALU.
// Latency: ALU answers L edges after capturing alu_ready; done expected nchunks*(L+3)+1 cycles after start.
// Backpressure: none; honours FP_CHUNK_SEQ_ZERO_MASKED_LANES_EN when building expected lanes.
module tb_fp_dot_product_chunk_sequencer;
    localparam int WIDTH      = 32;
    localparam int N          = 5;
    localparam int MAX_LEN    = 170;
    localparam int LEN_WIDTH  = $clog2(MAX_LEN + 1);
    localparam int NCH_MAX    = (MAX_LEN + N - 1) / N;
    localparam int ADDR_WIDTH = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1;

    typedef struct {
        logic [N-1:0]       en;
        logic [WIDTH-1:0]   c;
        logic [WIDTH*N-1:0] a;
        logic [WIDTH*N-1:0] b;
    } issue_t;

    logic clk = 1'b0;
    logic rst_r = 1'b0;
    logic start_r = 1'b0;
    logic [LEN_WIDTH-1:0] len_r = '0;
    logic [WIDTH*N-1:0] mem_a_q = '0;
    logic [WIDTH*N-1:0] mem_b_q = '0;
    logic alu_valid_r = 1'b0;
    logic [WIDTH-1:0] alu_out_r = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH*N-1:0] mem_a [NCH_MAX];
    logic [WIDTH*N-1:0] mem_b [NCH_MAX];
    int elem_a [NCH_MAX*N];
    int elem_b [NCH_MAX*N];

    issue_t           exp_issue[$];
    int               exp_addr[$];
    logic [WIDTH-1:0] exp_result[$];

    int alu_lat = 1;
    bit stray_en = 1'b0;

    always #5 clk = ~clk;

    fp_dot_product_chunk_sequencer_if #(.WIDTH(WIDTH), .NUM_INPUTS(N), .MAX_LEN(MAX_LEN)) bus ();

    assign bus.start      = start_r;
    assign bus.len        = len_r;
    assign bus.mem_a_data = mem_a_q;
    assign bus.mem_b_data = mem_b_q;
    assign bus.alu_valid  = alu_valid_r;
    assign bus.alu_out    = alu_out_r;

    fp_dot_product_chunk_sequencer #(.WIDTH(WIDTH), .NUM_INPUTS(N), .MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst_r),
        .bus (bus)
    );

    // Exact IEEE single encoding of a non-negative integer below 2^24.
    function automatic logic [31:0] int2f(input int v);
        int e;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 31; i++) if (v[i]) e = i;
        m = 32'(v) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic int f2int(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        if (e < 0 || e > 23) return -1;
        m = {8'h0, 1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [N-1:0] lane_mask(input int rem);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = (i < rem);
        return m;
    endfunction

    task automatic check(input string name, input logic [WIDTH*N-1:0] act, input logic [WIDTH*N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, {bus.busy, bus.done, bus.mem_rd_en, bus.alu_ready, bus.alu_mode}, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_alu_c"}, bus.alu_c, 0);
        check({tag, "_enable"}, bus.alu_enable, 0);
    endtask

    // Operand memories: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            mem_a_q <= mem_a[bus.mem_addr];
            mem_b_q <= mem_b[bus.mem_addr];
        end
    end

    // Behavioural ALU: c + sum of enabled lane products, answered alu_lat edges after the issue edge.
    int cyc = 0, due = 0, stray_at = 0;
    bit pend = 1'b0, stray_pend = 1'b0;
    logic [WIDTH-1:0] pend_val = '0;
    always @(posedge clk) begin
        logic v;
        logic [WIDTH-1:0] o;
        int s;
        cyc++;
        v = 1'b0;
        o = '0;
        if (pend && cyc == due) begin
            v = 1'b1;
            o = pend_val;
            pend = 1'b0;
            stray_pend = stray_en;
            stray_at = cyc + 1;
        end else if (stray_pend && cyc == stray_at) begin
            v = 1'b1;
            o = 32'h447A0000;
            stray_pend = 1'b0;
        end
        if (bus.alu_ready) begin
            s = f2int(bus.alu_c);
            for (int i = 0; i < N; i++)
                if (bus.alu_enable[i])
                    s += f2int(bus.alu_a[i*WIDTH +: WIDTH]) * f2int(bus.alu_b[i*WIDTH +: WIDTH]);
            pend = 1'b1;
            due = cyc + alu_lat;
            pend_val = int2f(s);
        end
        alu_valid_r <= v;
        alu_out_r <= o;
    end

    // Monitor: pops the scoreboard whenever the DUT fetches, issues or finishes.
    always @(negedge clk) begin
        if (rst_r) begin
            if (bus.mem_rd_en) begin
                if (exp_addr.size() == 0) check("fetch_unexpected", bus.mem_rd_en, 0);
                else check("fetch_addr", bus.mem_addr, exp_addr.pop_front());
            end
            if (bus.alu_ready) begin
                if (exp_issue.size() == 0) begin
                    check("issue_unexpected", bus.alu_ready, 0);
                end else begin
                    issue_t it;
                    it = exp_issue.pop_front();
                    check("issue_enable", bus.alu_enable, it.en);
                    check("issue_c", bus.alu_c, it.c);
                    check("issue_a", bus.alu_a, it.a);
                    check("issue_b", bus.alu_b, it.b);
                end
            end else begin
                check("enable_idle", bus.alu_enable, 0);
            end
            if (bus.done) begin
                if (exp_result.size() == 0) check("done_unexpected", bus.done, 0);
                else check("result", bus.result, exp_result.pop_front());
            end
        end
    end

    task automatic fill(input int len, input int va, input int vb, input bit rnd, input bit nan_tail);
        logic [WIDTH-1:0] wa, wb;
        for (int e = 0; e < NCH_MAX*N; e++) begin
            if (e < len) begin
                elem_a[e] = rnd ? int'($urandom_range(0, 15)) : va;
                elem_b[e] = rnd ? int'($urandom_range(0, 15)) : vb;
                wa = int2f(elem_a[e]);
                wb = int2f(elem_b[e]);
            end else begin
                elem_a[e] = 0;
                elem_b[e] = 0;
                wa = nan_tail ? 32'h7FC00000 : $urandom;
                wb = nan_tail ? 32'h7FC00000 : $urandom;
            end
            mem_a[e / N][(e % N)*WIDTH +: WIDTH] = wa;
            mem_b[e / N][(e % N)*WIDTH +: WIDTH] = wb;
        end
    endtask

    task automatic run(input int len, input int lat, input bit noise, input bit rst_mid);
        int nch, sum, cyc_cnt, limit;
        logic [WIDTH-1:0] exp_res, wa, wb;
        issue_t it;
        nch = (len + N - 1) / N;
        alu_lat = lat;
        stray_en = noise;
        sum = 0;
        for (int k = 0; k < nch; k++) begin
            it.en = (k == nch - 1) ? lane_mask(len - (nch - 1)*N) : '1;
            it.c = int2f(sum);
            for (int i = 0; i < N; i++) begin
                wa = mem_a[k][i*WIDTH +: WIDTH];
                wb = mem_b[k][i*WIDTH +: WIDTH];
`ifdef FP_CHUNK_SEQ_ZERO_MASKED_LANES_EN
                if (!it.en[i]) begin
                    wa = '0;
                    wb = '0;
                end
`endif
                it.a[i*WIDTH +: WIDTH] = wa;
                it.b[i*WIDTH +: WIDTH] = wb;
                if (it.en[i]) sum += elem_a[k*N + i] * elem_b[k*N + i];
            end
            exp_issue.push_back(it);
            exp_addr.push_back(k);
        end
        exp_res = int2f(sum);
        if (!rst_mid) exp_result.push_back(exp_res);

        @(negedge clk);
        start_r = 1'b1;
        len_r = LEN_WIDTH'(len);
        @(negedge clk);
        start_r = 1'b0;
        cyc_cnt = 1;
        limit = nch*(lat + 3) + 20;
        while (!bus.done && cyc_cnt < limit) begin
            check("mode_busy", {bus.busy, bus.alu_mode}, 2'b11);
            if (rst_mid && !bus.mem_rd_en && !bus.alu_ready) begin
                rst_r = 1'b0;
                @(negedge clk);
                check_reset("rst_mid");
                exp_issue.delete();
                exp_addr.delete();
                rst_r = 1'b1;
                repeat (lat + 4) @(negedge clk);
                check("late_valid_busy", bus.busy, 0);
                check("late_valid_result", bus.result, 0);
                return;
            end
            if (noise && $urandom_range(0, 2) == 0) begin
                start_r = 1'b1;
                len_r = LEN_WIDTH'($urandom_range(0, MAX_LEN));
            end
            @(negedge clk);
            start_r = 1'b0;
            cyc_cnt++;
        end
        if (!bus.done) begin
            check("done_timeout", bus.done, 1);
            rst_r = 1'b0;
            @(negedge clk);
            rst_r = 1'b1;
            exp_issue.delete();
            exp_addr.delete();
            exp_result.delete();
            repeat (lat + 4) @(negedge clk);
            return;
        end
        check("latency", cyc_cnt, nch*(lat + 3) + 1);
        @(negedge clk);
        check("result_hold", bus.result, exp_res);
        check("idle_mode", {bus.busy, bus.alu_mode}, 0);
        check("scoreboard_drained", exp_issue.size() + exp_addr.size() + exp_result.size(), 0);
    endtask

    initial begin
        int len;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_r = 1'b1;

        fill(5, 1, 2, 1'b0, 1'b0);   run(5, 2, 1'b0, 1'b0);
        fill(12, 1, 1, 1'b0, 1'b0);  run(12, 3, 1'b0, 1'b0);
        fill(0, 0, 0, 1'b1, 1'b0);   run(0, 2, 1'b0, 1'b0);
        fill(3, 0, 0, 1'b1, 1'b1);   run(3, 2, 1'b0, 1'b0);
        fill(17, 0, 0, 1'b1, 1'b0);  run(17, 2, 1'b1, 1'b0);
        fill(12, 0, 0, 1'b1, 1'b0);  run(12, 3, 1'b0, 1'b1);
        fill(5, 0, 0, 1'b1, 1'b0);   run(5, 1, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            if (r == 0) len = MAX_LEN;
            else if (r == 1) len = 1;
            else if (r == 2) len = MAX_LEN - N;
            else len = int'($urandom_range(0, MAX_LEN));
            fill(len, 0, 0, 1'b1, ($urandom_range(0, 1) == 1));
            run(len, int'($urandom_range(1, 4)), ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fp_dot_product_chunk_sequencer.md
# fp_dot_product_chunk_sequencer

Upstream control stage for the dot-product ALU. Computes one long floating-point dot product of `len` elements by splitting it into `NUM_INPUTS`-wide chunks. Each chunk is read from a pair of operand memories and issued to the ALU in dot-product mode, with the running partial sum fed back through the ALU's `c` input. Rows are processed serially, and the block holds the ALU in dot-product mode only while busy.

## Interface
- `WIDTH`, 32, float word width (IEEE-754 single).
- `NUM_INPUTS`, 5, lanes per chunk; must match the ALU.
- `MAX_LEN`, 170, largest supported `len`.
- `LEN_WIDTH`, `$clog2(MAX_LEN+1)`, width of `len`.
- `ADDR_WIDTH`, `$clog2((MAX_LEN+NUM_INPUTS-1)/NUM_INPUTS)`, chunk address width (minimum 1).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: request a dot product; sampled only in IDLE.
- `len` in LEN_WIDTH: element count, 0..MAX_LEN; latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out WIDTH: final sum; registered and held until the next accepted `start`.
- `mem_rd_en` out 1: operand memory read strobe.
- `mem_addr` out ADDR_WIDTH: chunk index.
- `mem_a_data`, `mem_b_data` in WIDTH*NUM_INPUTS: operand chunks; arrive exactly 1 cycle after `mem_rd_en`. Lane i is bits `[WIDTH*(i+1)-1 : WIDTH*i]`.
- `alu_a`, `alu_b` out WIDTH*NUM_INPUTS: connect to `dot_product_a`/`dot_product_b`.
- `alu_c` out WIDTH: partial sum; connect to `dot_product_c`.
- `alu_enable` out NUM_INPUTS: lane mask.
- `alu_ready` out 1: one-cycle issue strobe to the ALU `ready`.
- `alu_mode` out 1: drives `dot_product_mode`; equals `busy`.
- `alu_out` in WIDTH: ALU `dot_product_out`.
- `alu_valid` in 1: ALU `dot_product_valid`.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE with `start`=1:
  - Latch `len`.
  - Set `nchunks` = ceil(len/NUM_INPUTS), `k` = 0, `acc` = 0.
  - Go to FETCH if `len` > 0, else go to DONE.
- FETCH: `mem_rd_en`=1 and `mem_addr`=k for one cycle, then go to ISSUE.
- ISSUE, one cycle, then go to WAIT:
  - `alu_ready`=1; `alu_a`/`alu_b` = `mem_a_data`/`mem_b_data`; `alu_c` = `acc`.
  - `alu_enable` = all ones, except on the last chunk (k = nchunks-1), where lane i is enabled iff i < rem.
  - rem = len - (nchunks-1)*NUM_INPUTS, in 1..NUM_INPUTS.
- WAIT:
  - On `alu_valid`=1: `acc` <= `alu_out`, `k` <= k+1.
  - Then go to FETCH if k+1 < nchunks, else go to DONE.
- DONE: `done`=1 and `result` <= `acc`, for one cycle, then go to IDLE.
- `acc` is a 0.0 bit pattern (`32'h0`) at the start of every dot product. For `len`=0 the result is `32'h0`.
- `start` outside IDLE is ignored; the operation in flight is unaffected.
- `alu_valid` outside WAIT is ignored.
- Outside ISSUE: `alu_ready`=0, `alu_a`/`alu_b` pass memory data, `alu_c`=`acc`, `alu_enable`=0.
- Reset, including mid-operation: return to IDLE with all counters zero. Any later ALU result is discarded because `alu_valid` is ignored in IDLE.
- `len` > MAX_LEN is unsupported; behaviour is undefined.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `mem_rd_en`=0, `mem_addr`=0, `alu_ready`=0, `alu_mode`=0, `alu_c`=0, `alu_enable`=0.
- With `start` accepted at edge T:
  - FETCH in cycle T+1.
  - ISSUE in cycle T+2.
  - With ALU latency L, `alu_valid` arrives at T+2+L.
  - The next FETCH, or DONE, follows in the cycle after `alu_valid`.
- Per-chunk cost is L+3 cycles. Total latency from `start` to `done` is nchunks*(L+3)+1 cycles.
- For `len`=0, `done` is asserted in cycle T+1.
- The earliest next `start` is accepted in the cycle after `done`.

## Configuration
- `FP_CHUNK_SEQ_ZERO_MASKED_LANES_EN`
- Defined: `alu_a` and `alu_b` lanes with `alu_enable`[i]=0 are forced to `32'h0`, so NaN or Inf memory contents never reach the multipliers.
- Undefined: memory data passes through unmodified, and masking relies solely on `alu_enable`.
- The dot-product result is identical in both builds.

## Test plan
- `len`=5, all a=1.0 (`3F800000`), all b=2.0: one issue, `alu_enable`=`11111`, `alu_c`=0 → `result`=`41200000` (10.0).
- `len`=12, all a=b=1.0:
  - Three issues with `alu_enable` `11111`, `11111`, `00011` and `alu_c` 0, 5.0, 10.0.
  - Required: `result`=`41400000` (12.0); `done` exactly 3*(L+3)+1 cycles after `start`.
- `len`=0: `done` at T+1, `result`=0, no `mem_rd_en` and no `alu_ready` pulses.
- `start` re-pulsed during WAIT, plus a stray `alu_valid` injected during FETCH: no state change, `acc` unchanged, final result correct.
- `rst`=0 for one cycle during WAIT: all outputs at reset values after the edge. A late `alu_valid` is ignored. A following `len`=5 run produces the correct result.
- `len`=3 with memory lanes 3–4 set to NaN (`7FC00000`):
  - Macro defined: `alu_a`/`alu_b` lanes 3–4 = 0.
  - Macro undefined: lanes 3–4 = NaN.
  - `alu_enable`=`00111` and the numeric result match in both builds.
